// File: rtl/cache_pkg.sv
// Shared constants and types for the direct-mapped write-back data cache.
package cache_pkg;

  localparam int unsigned ADDR_W     = 30;
  localparam int unsigned TAG_W      = 25;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned OFF_W      = 2;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned MEM_ADDR_W = ADDR_W - OFF_W;

  typedef enum logic [1:0] {
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  // Word w of a block lives at bits [32w+31:32w].
  function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_W-1:0] blk,
                                                 input logic [OFF_W-1:0]   off);
    return blk[off*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/cache_line_array.sv
// Tag/valid/dirty/data storage: combinational read, synchronous word write or block fill.
module cache_line_array
  import cache_pkg::*;
#(
  parameter int unsigned NumLines = 8,
  parameter int unsigned TagW     = 25,
  parameter int unsigned LineW    = 128
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [$clog2(NumLines)-1:0] idx_i,
  output logic                        valid_o,
  output logic                        dirty_o,
  output logic [TagW-1:0]             tag_o,
  output logic [LineW-1:0]            line_o,
  input  logic                        word_we_i,
  input  logic [OFF_W-1:0]            word_off_i,
  input  logic [WORD_W-1:0]           word_i,
  input  logic                        fill_i,
  input  logic [TagW-1:0]             fill_tag_i,
  input  logic [LineW-1:0]            fill_line_i
);

  logic [NumLines-1:0] valid_q;
  logic [NumLines-1:0] dirty_q;
  logic [TagW-1:0]     tag_q  [NumLines];
  logic [LineW-1:0]    data_q [NumLines];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_i) begin
      valid_q[idx_i] <= 1'b1;
      dirty_q[idx_i] <= 1'b0;
    end else if (word_we_i) begin
      dirty_q[idx_i] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tag_q[idx_i]  <= fill_tag_i;
      data_q[idx_i] <= fill_line_i;
    end else if (word_we_i) begin
      data_q[idx_i][word_off_i*WORD_W +: WORD_W] <= word_i;
    end
  end

  assign valid_o = valid_q[idx_i];
  assign dirty_o = dirty_q[idx_i];
  assign tag_o   = tag_q[idx_i];
  assign line_o  = data_q[idx_i];

endmodule

// File: rtl/dcache_wb_dm.sv
// Direct-mapped write-back write-allocate data cache with a 128-bit block memory port.
module dcache_wb_dm
  import cache_pkg::*;
#(
  parameter int unsigned NUM_LINES      = 8,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic                                 clk_i,
  input  logic                                 proc_reset_i,
  input  logic                                 proc_read_i,
  input  logic                                 proc_write_i,
  input  logic [ADDR_W-1:0]                    proc_addr_i,
  input  logic [WORD_W-1:0]                    proc_wdata_i,
  output logic [WORD_W-1:0]                    proc_rdata_o,
  output logic                                 proc_stall_o,
  output logic                                 mem_read_o,
  output logic                                 mem_write_o,
  output logic [MEM_ADDR_W-1:0]                mem_addr_o,
  output logic [WORDS_PER_LINE*WORD_W-1:0]     mem_wdata_o,
  input  logic [WORDS_PER_LINE*WORD_W-1:0]     mem_rdata_i,
  input  logic                                 mem_ready_i
);

  localparam int unsigned IdxW  = $clog2(NUM_LINES);
  localparam int unsigned TagW  = TAG_W + IDX_W - IdxW;
  localparam int unsigned LineW = WORDS_PER_LINE * WORD_W;

  state_e state_q, state_d;
  logic   mem_read_q, mem_read_d;
  logic   mem_write_q, mem_write_d;

  logic [TagW-1:0]  req_tag;
  logic [IdxW-1:0]  req_idx;
  logic [OFF_W-1:0] req_off;
  logic             req;
  logic             hit;

  logic             line_valid;
  logic             line_dirty;
  logic [TagW-1:0]  line_tag;
  logic [LineW-1:0] line_data;
  logic             word_we;
  logic             fill;

  assign req_tag = proc_addr_i[ADDR_W-1 -: TagW];
  assign req_idx = proc_addr_i[OFF_W +: IdxW];
  assign req_off = proc_addr_i[OFF_W-1:0];
  assign req     = proc_read_i | proc_write_i;
  assign hit     = line_valid && (line_tag == req_tag);

  cache_line_array #(
    .NumLines (NUM_LINES),
    .TagW     (TagW),
    .LineW    (LineW)
  ) u_lines (
    .clk_i       (clk_i),
    .rst_i       (proc_reset_i),
    .idx_i       (req_idx),
    .valid_o     (line_valid),
    .dirty_o     (line_dirty),
    .tag_o       (line_tag),
    .line_o      (line_data),
    .word_we_i   (word_we),
    .word_off_i  (req_off),
    .word_i      (proc_wdata_i),
    .fill_i      (fill),
    .fill_tag_i  (req_tag),
    .fill_line_i (mem_rdata_i)
  );

  always_ff @(posedge clk_i) begin
    if (proc_reset_i) begin
      state_q     <= COMPARE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      COMPARE: begin
        if (req && !hit) begin
          state_d = (line_valid && line_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: if (mem_ready_i) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ready_i) state_d = COMPARE;
      default:   state_d = COMPARE;
    endcase
    // Memory strobes are registered copies of the upcoming state.
    mem_write_d = (state_d == WRITEBACK);
    mem_read_d  = (state_d == ALLOCATE);
  end

  always_comb begin
    proc_stall_o = 1'b0;
    proc_rdata_o = '0;
    word_we      = 1'b0;
    fill         = 1'b0;
    mem_addr_o   = proc_addr_i[ADDR_W-1:OFF_W];
    unique case (state_q)
      COMPARE: begin
        proc_stall_o = req && !hit;
        word_we      = hit && proc_write_i;
        if (hit && proc_read_i) proc_rdata_o = get_word(line_data, req_off);
      end
      WRITEBACK: begin
        proc_stall_o = 1'b1;
        mem_addr_o   = {line_tag, req_idx};
      end
      ALLOCATE: begin
        proc_stall_o = 1'b1;
        fill         = mem_ready_i;
      end
      default: ;
    endcase
    if (proc_reset_i) begin
      proc_stall_o = 1'b0;
      proc_rdata_o = '0;
      word_we      = 1'b0;
      fill         = 1'b0;
    end
  end

  assign mem_read_o  = mem_read_q;
  assign mem_write_o = mem_write_q;
  assign mem_wdata_o = line_data;

endmodule

// File: tb/tb_dcache_wb_dm.sv
// Directed and randomized checks of dcache_wb_dm against a word-level reference memory.
module tb_dcache_wb_dm;

  logic         clk;
  logic         proc_reset;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  int tests;
  int fails;
  int overlap_total;

  logic [31:0] mem_words [1024];
  logic [31:0] ref_words [128];

  logic [31:0]  acc_rdata;
  int           acc_stall;
  int           acc_rd_cyc;
  int           acc_wr_cyc;
  logic [27:0]  acc_wb_addr;
  logic [27:0]  acc_rf_addr;
  logic [127:0] acc_wb_data;
  logic         acc_wb_before_rf;
  logic         acc_timeout;

  dcache_wb_dm #(
    .NUM_LINES      (8),
    .WORDS_PER_LINE (4)
  ) dut (
    .clk_i        (clk),
    .proc_reset_i (proc_reset),
    .proc_read_i  (proc_read),
    .proc_write_i (proc_write),
    .proc_addr_i  (proc_addr),
    .proc_wdata_i (proc_wdata),
    .proc_rdata_o (proc_rdata),
    .proc_stall_o (proc_stall),
    .mem_read_o   (mem_read),
    .mem_write_o  (mem_write),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ready_i  (mem_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  // Word i of memory initially holds {AAAA + 1111*i, i} (16-bit fields).
  function automatic logic [31:0] init_word(input int i);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = 16'(i);
    hi = 16'hAAAA + 16'h1111 * lo;
    return {hi, lo};
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkint(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; acts as the memory while the cache stalls.
  task automatic access(input logic wr, input logic [29:0] addr, input logic [31:0] wd,
                        input int lat);
    int lat_cnt;
    int guard;
    logic [7:0] blk;
    lat_cnt          = 0;
    guard            = 0;
    acc_stall        = 0;
    acc_rd_cyc       = 0;
    acc_wr_cyc       = 0;
    acc_wb_before_rf = 1'b0;
    acc_timeout      = 1'b0;
    acc_wb_addr      = '0;
    acc_rf_addr      = '0;
    acc_wb_data      = '0;
    proc_write       = wr;
    proc_read        = !wr;
    proc_addr        = addr;
    proc_wdata       = wd;
    forever begin
      #1;
      if (!proc_stall) break;
      if (guard == 400) begin
        acc_timeout = 1'b1;
        break;
      end
      guard++;
      acc_stall++;
      if (mem_read && mem_write) overlap_total++;
      if (mem_write) begin
        if (acc_wr_cyc == 0) begin
          acc_wb_addr = mem_addr;
          acc_wb_data = mem_wdata;
        end
        acc_wr_cyc++;
      end
      if (mem_read) begin
        if (acc_rd_cyc == 0) begin
          acc_rf_addr      = mem_addr;
          acc_wb_before_rf = (acc_wr_cyc > 0);
        end
        acc_rd_cyc++;
      end
      if (mem_read || mem_write) begin
        lat_cnt++;
        if (lat_cnt >= lat) begin
          lat_cnt   = 0;
          mem_ready = 1'b1;
          blk       = mem_addr[7:0];
          if (mem_write) begin
            for (int w = 0; w < 4; w++) mem_words[{blk, 2'(w)}] = mem_wdata[32*w +: 32];
          end else begin
            mem_rdata = {mem_words[{blk, 2'd3}], mem_words[{blk, 2'd2}],
                         mem_words[{blk, 2'd1}], mem_words[{blk, 2'd0}]};
          end
        end
      end
      @(negedge clk);
      mem_ready = 1'b0;
    end
    acc_rdata = proc_rdata;
    check1("no_timeout", acc_timeout, 1'b0);
    @(negedge clk);
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  initial begin
    int a;
    int lat;
    logic wr;
    logic [31:0] wd;

    tests         = 0;
    fails         = 0;
    overlap_total = 0;
    proc_reset    = 1'b1;
    proc_read     = 1'b0;
    proc_write    = 1'b0;
    proc_addr     = '0;
    proc_wdata    = '0;
    mem_rdata     = '0;
    mem_ready     = 1'b0;
    for (int i = 0; i < 1024; i++) mem_words[i] = init_word(i);
    for (int i = 0; i < 128; i++) ref_words[i] = mem_words[i];

    repeat (2) @(negedge clk);
    proc_reset = 1'b0;
    #1;
    check1("rst_stall", proc_stall, 1'b0);
    check1("rst_mem_read", mem_read, 1'b0);
    check1("rst_mem_write", mem_write, 1'b0);
    check32("rst_rdata", proc_rdata, 32'h0);
    @(negedge clk);

    // 1: cold read miss, memory answers on the third request cycle
    access(1'b0, 30'h00, 32'h0, 3);
    check32("t1_rdata", acc_rdata, 32'hAAAA0000);
    check32("t1_rf_addr", {4'h0, acc_rf_addr}, 32'h0);
    checkint("t1_rd_cycles", acc_rd_cyc, 3);
    checkint("t1_wr_cycles", acc_wr_cyc, 0);
    checkint("t1_stall_cycles", acc_stall, 4);

    // 2: read hit
    access(1'b0, 30'h02, 32'h0, 1);
    check32("t2_rdata", acc_rdata, 32'hCCCC0002);
    checkint("t2_stall_cycles", acc_stall, 0);
    checkint("t2_mem_cycles", acc_rd_cyc + acc_wr_cyc, 0);

    // 3: write hit then read back
    access(1'b1, 30'h01, 32'h12345678, 1);
    ref_words[1] = 32'h12345678;
    checkint("t3_wr_stall", acc_stall, 0);
    access(1'b0, 30'h01, 32'h0, 1);
    check32("t3_rdata", acc_rdata, 32'h12345678);
    checkint("t3_rd_stall", acc_stall, 0);

    // 4: conflicting tag forces writeback of the dirty line, then refill
    access(1'b0, 30'h20, 32'h0, 2);
    check32("t4_wb_addr", {4'h0, acc_wb_addr}, 32'h0);
    check128("t4_wb_data", acc_wb_data,
             {32'hDDDD0003, 32'hCCCC0002, 32'h12345678, 32'hAAAA0000});
    check32("t4_rf_addr", {4'h0, acc_rf_addr}, 32'h8);
    check1("t4_wb_before_rf", acc_wb_before_rf, 1'b1);
    check32("t4_rdata", acc_rdata, 32'hCCCA0020);
    checkint("t4_stall_cycles", acc_stall, 5);

    // 5: reset while a refill is outstanding; a late mem_ready must be ignored
    proc_read = 1'b1;
    proc_addr = 30'h40;
    #1;
    check1("t5_miss_stall", proc_stall, 1'b1);
    @(negedge clk);
    check1("t5_mem_read", mem_read, 1'b1);
    check32("t5_mem_addr", {4'h0, mem_addr}, 32'h10);
    proc_reset = 1'b1;
    #1;
    check1("t5_stall_in_reset", proc_stall, 1'b0);
    check32("t5_rdata_in_reset", proc_rdata, 32'h0);
    @(negedge clk);
    proc_reset = 1'b0;
    proc_read  = 1'b0;
    mem_ready  = 1'b1;
    mem_rdata  = {4{32'hDEADBEEF}};
    #1;
    check1("t5_mem_read_after_rst", mem_read, 1'b0);
    check1("t5_stall_after_rst", proc_stall, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    check1("t5_stray_ready_rd", mem_read, 1'b0);
    check1("t5_stray_ready_wr", mem_write, 1'b0);
    @(negedge clk);
    access(1'b0, 30'h00, 32'h0, 1);
    checkint("t5_remiss_rd_cycles", acc_rd_cyc, 1);
    check32("t5_remiss_rdata", acc_rdata, 32'hAAAA0000);

    // 6: random traffic over 32 blocks (4 tags per index) with 1-10 cycle memory latency
    for (int n = 0; n < 1000; n++) begin
      a   = int'($urandom_range(0, 127));
      lat = int'($urandom_range(1, 10));
      wr  = 1'($urandom_range(0, 1));
      wd  = $urandom;
      access(wr, 30'(a), wd, lat);
      if (wr) ref_words[a] = wd;
      else check32("t6_rand_read", acc_rdata, ref_words[a]);
    end
    checkint("t6_rd_wr_overlap", overlap_total, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
